// File: rtl/controller.sv
// controller: main opcode decoder for the single-cycle RV32I datapath.
// Ports: clk, rst (sync, active-high), instruction[6:0] -> strobes, Illegal, IllegalSeen.
module controller (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] instruction,
   output logic       Branch,
   output logic [1:0] ALUOp,
   output logic       ALUSrc,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       Mem2Reg,
   output logic       RegWrite,
   output logic       Jal,
   output logic       Jalr,
   output logic       Lui,
   output logic       Auipc,
   output logic       Illegal,
   output logic       IllegalSeen
);

   localparam logic [6:0] OP_R     = 7'h33;
   localparam logic [6:0] OP_I     = 7'h13;
   localparam logic [6:0] OP_LOAD  = 7'h03;
   localparam logic [6:0] OP_STORE = 7'h23;
   localparam logic [6:0] OP_BR    = 7'h63;
   localparam logic [6:0] OP_JAL   = 7'h6F;
   localparam logic [6:0] OP_JALR  = 7'h67;
   localparam logic [6:0] OP_LUI   = 7'h37;
   localparam logic [6:0] OP_AUIPC = 7'h17;
   localparam logic [6:0] OP_SYS   = 7'h73;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_CMP = 2'b01;
   localparam logic [1:0] ALU_FN  = 2'b10;

   // Equality compares yield X on unknown bits, so an X/Z opcode
   // matches no arm and lands in the illegal default.
   always_comb begin
      Branch   = 1'b0;
      ALUOp    = ALU_ADD;
      ALUSrc   = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      Mem2Reg  = 1'b0;
      RegWrite = 1'b0;
      Jal      = 1'b0;
      Jalr     = 1'b0;
      Lui      = 1'b0;
      Auipc    = 1'b0;
      Illegal  = 1'b0;
      unique case (1'b1)
         (instruction == OP_R): begin
            RegWrite = 1'b1;
            ALUOp    = ALU_FN;
         end
         (instruction == OP_I): begin
            RegWrite = 1'b1;
            ALUSrc   = 1'b1;
            ALUOp    = ALU_FN;
         end
         (instruction == OP_LOAD): begin
            ALUSrc   = 1'b1;
            MemRead  = 1'b1;
            Mem2Reg  = 1'b1;
            RegWrite = 1'b1;
         end
         (instruction == OP_STORE): begin
            ALUSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         (instruction == OP_BR): begin
            Branch = 1'b1;
            ALUOp  = ALU_CMP;
         end
         (instruction == OP_JAL): begin
            Jal      = 1'b1;
            RegWrite = 1'b1;
         end
         (instruction == OP_JALR): begin
            Jalr     = 1'b1;
            ALUSrc   = 1'b1;
            RegWrite = 1'b1;
         end
         (instruction == OP_LUI): begin
            Lui      = 1'b1;
            ALUSrc   = 1'b1;
            RegWrite = 1'b1;
         end
         (instruction == OP_AUIPC): begin
            Auipc    = 1'b1;
            ALUSrc   = 1'b1;
            RegWrite = 1'b1;
         end
         // ECALL/EBREAK pass through as a NOP here
         (instruction == OP_SYS): begin
         end
         default: begin
            Illegal = 1'b1;
         end
      endcase
   end

   // Sticky: reset wins over a simultaneous illegal opcode
   always_ff @(posedge clk) begin
      if (rst) begin
         IllegalSeen <= 1'b0;
      end else if (Illegal) begin
         IllegalSeen <= 1'b1;
      end
   end

endmodule

// File: tb/tb_controller.sv
// tb_controller: directed table check of controller decode,
// sticky illegal flag sequence, and full 128-opcode sweep.
module tb_controller;

   logic       clk;
   logic       rst;
   logic [6:0] instruction;
   logic       Branch;
   logic [1:0] ALUOp;
   logic       ALUSrc;
   logic       MemRead;
   logic       MemWrite;
   logic       Mem2Reg;
   logic       RegWrite;
   logic       Jal;
   logic       Jalr;
   logic       Lui;
   logic       Auipc;
   logic       Illegal;
   logic       IllegalSeen;

   int checks = 0;
   int errors = 0;

   controller dut (
      .clk        (clk),
      .rst        (rst),
      .instruction(instruction),
      .Branch     (Branch),
      .ALUOp      (ALUOp),
      .ALUSrc     (ALUSrc),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .Mem2Reg    (Mem2Reg),
      .RegWrite   (RegWrite),
      .Jal        (Jal),
      .Jalr       (Jalr),
      .Lui        (Lui),
      .Auipc      (Auipc),
      .Illegal    (Illegal),
      .IllegalSeen(IllegalSeen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {Branch, ALUOp, ALUSrc, MemRead, MemWrite, Mem2Reg,
   //  RegWrite, Jal, Jalr, Lui, Auipc, Illegal}
   typedef struct {
      logic [6:0]  opc;
      logic [12:0] exp;
      string       name;
   } vec_t;

   vec_t tbl[12];

   function automatic logic [12:0] pack_out();
      return {Branch, ALUOp, ALUSrc, MemRead, MemWrite, Mem2Reg,
              RegWrite, Jal, Jalr, Lui, Auipc, Illegal};
   endfunction

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic bit is_legal(input logic [6:0] o);
      return o == 7'h33 || o == 7'h13 || o == 7'h03 || o == 7'h23 ||
             o == 7'h63 || o == 7'h6F || o == 7'h67 || o == 7'h37 ||
             o == 7'h17 || o == 7'h73;
   endfunction

   initial begin
      int nill;
      //                       B  AO    S  MR MW M2 RW J  JR L  A  IL
      tbl[0]  = '{7'h33, 13'b0_10_0_0_0_0_1_0_0_0_0_0, "rtype"};
      tbl[1]  = '{7'h13, 13'b0_10_1_0_0_0_1_0_0_0_0_0, "iarith"};
      tbl[2]  = '{7'h03, 13'b0_00_1_1_0_1_1_0_0_0_0_0, "load"};
      tbl[3]  = '{7'h23, 13'b0_00_1_0_1_0_0_0_0_0_0_0, "store"};
      tbl[4]  = '{7'h63, 13'b1_01_0_0_0_0_0_0_0_0_0_0, "branch"};
      tbl[5]  = '{7'h6F, 13'b0_00_0_0_0_0_1_1_0_0_0_0, "jal"};
      tbl[6]  = '{7'h67, 13'b0_00_1_0_0_0_1_0_1_0_0_0, "jalr"};
      tbl[7]  = '{7'h37, 13'b0_00_1_0_0_0_1_0_0_1_0_0, "lui"};
      tbl[8]  = '{7'h17, 13'b0_00_1_0_0_0_1_0_0_0_1_0, "auipc"};
      tbl[9]  = '{7'h73, 13'b0_00_0_0_0_0_0_0_0_0_0_0, "system"};
      tbl[10] = '{7'h00, 13'b0_00_0_0_0_0_0_0_0_0_0_1, "op00"};
      tbl[11] = '{7'h7F, 13'b0_00_0_0_0_0_0_0_0_0_0_1, "op7f"};

      rst = 1'b1;
      instruction = 7'h33;
      @(posedge clk);
      #1;
      chk("reset_seen", {15'b0, IllegalSeen}, 16'h0);
      rst = 1'b0;

      foreach (tbl[i]) begin
         @(negedge clk);
         instruction = tbl[i].opc;
         #1;
         chk(tbl[i].name, {3'b0, pack_out()}, {3'b0, tbl[i].exp});
      end

      // Sticky flag sequence
      @(negedge clk);
      rst = 1'b1;
      instruction = 7'h33;
      @(posedge clk);
      #1;
      chk("seen_after_rst", {15'b0, IllegalSeen}, 16'h0);
      rst = 1'b0;
      @(negedge clk);
      instruction = 7'h0B;
      #1;
      chk("ill_imm", {15'b0, Illegal}, 16'h1);
      chk("seen_before_edge", {15'b0, IllegalSeen}, 16'h0);
      @(posedge clk);
      #1;
      chk("seen_set", {15'b0, IllegalSeen}, 16'h1);
      @(negedge clk);
      instruction = 7'h33;
      #1;
      chk("ill_clear", {15'b0, Illegal}, 16'h0);
      @(posedge clk);
      #1;
      chk("seen_holds", {15'b0, IllegalSeen}, 16'h1);
      @(negedge clk);
      rst = 1'b1;
      instruction = 7'h0B;
      @(posedge clk);
      #1;
      chk("rst_priority", {15'b0, IllegalSeen}, 16'h0);
      @(negedge clk);
      rst = 1'b0;
      instruction = 7'h33;
      @(posedge clk);
      #1;
      chk("seen_stays0", {15'b0, IllegalSeen}, 16'h0);

      // Sweep all opcodes
      nill = 0;
      for (int o = 0; o < 128; o++) begin
         @(negedge clk);
         instruction = 7'(o);
         #1;
         chk($sformatf("mem_excl_%02h", o),
             {15'b0, MemRead & MemWrite}, 16'h0);
         chk($sformatf("m2r_%02h", o),
             {15'b0, Mem2Reg & ~MemRead}, 16'h0);
         chk($sformatf("onehot_%02h", o),
             {15'b0, $countones({Branch, Jal, Jalr, Lui, Auipc}) > 1},
             16'h0);
         chk($sformatf("illegal_%02h", o), {15'b0, Illegal},
             {15'b0, !is_legal(7'(o))});
         if (Illegal === 1'b1) nill++;
      end
      chk("illegal_count", 16'(nill), 16'd118);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/controller.md
Name: controller

Overview:
- Main control decoder for the single-cycle RV32I datapath; sits between instruction fetch/decode and the datapath muxes, ALU control, data memory and register file.
- Decodes the 7-bit opcode field (instr[6:0]) into datapath control strobes combinationally.
- Flags unsupported opcodes, both instantaneously and in a sticky register that the rest of the design can read for debug and trap purposes.

Parameters:
- None.

Ports:
- clk  input  1  system clock; clocks only the sticky error register.
- rst  input  1  synchronous, active-high reset.
- instruction  input  7  opcode field instr[6:0].
- Branch  output  1  conditional-branch instruction (B-type).
- ALUOp  output  2  ALU control class: 00 = add (address/pass), 01 = compare (branch), 10 = funct-decoded (R/I arithmetic).
- ALUSrc  output  1  ALU operand B select: 0 = rs2, 1 = immediate.
- MemRead  output  1  data-memory read enable.
- MemWrite  output  1  data-memory write enable.
- Mem2Reg  output  1  write-back select: 0 = ALU result, 1 = memory data.
- RegWrite  output  1  register-file write enable.
- Jal  output  1  JAL instruction.
- Jalr  output  1  JALR instruction.
- Lui  output  1  LUI instruction.
- Auipc  output  1  AUIPC instruction.
- Illegal  output  1  current opcode is unsupported (combinational).
- IllegalSeen  output  1  sticky flag: an unsupported opcode has been sampled on a clk edge since the last reset.

Behaviour:
- All decode outputs, including Illegal, are purely combinational from instruction.
  - Zero clock latency; outputs settle within the same cycle.
  - rst and clk have no effect on them.
- Every output not listed for an opcode below is 0.
- Opcode decode, listing the outputs driven to 1 (or to the stated value):
  - 0x33 R-type: RegWrite=1, ALUOp=10, ALUSrc=0.
  - 0x13 I-arith: RegWrite=1, ALUSrc=1, ALUOp=10.
  - 0x03 load: ALUSrc=1, MemRead=1, Mem2Reg=1, RegWrite=1, ALUOp=00.
  - 0x23 store: ALUSrc=1, MemWrite=1, ALUOp=00, RegWrite=0.
  - 0x63 branch: Branch=1, ALUOp=01, ALUSrc=0, RegWrite=0.
  - 0x6F JAL: Jal=1, RegWrite=1, ALUOp=00.
  - 0x67 JALR: Jalr=1, ALUSrc=1, RegWrite=1, ALUOp=00.
  - 0x37 LUI: Lui=1, ALUSrc=1, RegWrite=1, ALUOp=00.
  - 0x17 AUIPC: Auipc=1, ALUSrc=1, RegWrite=1, ALUOp=00.
  - 0x73 system (ECALL/EBREAK): all outputs 0, Illegal=0. Treated as a NOP by this block.
  - Any other value, including 0x00 and 0x7F: all strobes 0, ALUOp=00, Illegal=1.
- Safety invariants, true for every input value:
  - MemRead and MemWrite are never both 1.
  - Mem2Reg=1 only when MemRead=1.
  - At most one of Branch/Jal/Jalr/Lui/Auipc is 1.
- IllegalSeen register:
  - Reset value 0.
  - On a rising clk edge: if rst=1, it becomes 0 (rst has priority over a simultaneous illegal opcode).
  - Otherwise, if Illegal=1, it becomes 1.
  - Otherwise it holds its value.
  - Once set, it stays 1 until the next rst, regardless of subsequent legal opcodes.
- X/Z on instruction bits: an unknown opcode decodes as illegal. Simulation behaviour is otherwise don't-care.

Test Plan:
- R-type: instruction=0x33, wait 10 ns -> Branch=0, ALUOp=10, ALUSrc=0, MemRead=0, MemWrite=0, Mem2Reg=0, RegWrite=1, Illegal=0.
- I-arith and load:
  - instruction=0x13 -> ALUOp=10, ALUSrc=1, RegWrite=1, all other outputs 0.
  - instruction=0x03 -> ALUOp=00, ALUSrc=1, MemRead=1, Mem2Reg=1, RegWrite=1, all other outputs 0.
- Store and branch:
  - instruction=0x23 -> ALUSrc=1, MemWrite=1, RegWrite=0, ALUOp=00.
  - instruction=0x63 -> Branch=1, ALUOp=01, ALUSrc=0, RegWrite=0, MemRead=0, MemWrite=0.
- Jumps and upper-immediates, each with all other outputs 0:
  - 0x6F -> Jal=1, RegWrite=1.
  - 0x67 -> Jalr=1, ALUSrc=1, RegWrite=1.
  - 0x37 -> Lui=1, ALUSrc=1, RegWrite=1.
  - 0x17 -> Auipc=1, ALUSrc=1, RegWrite=1.
- Illegal and sticky flag sequence:
  - rst=1 for 1 clk -> IllegalSeen=0.
  - instruction=0x0B -> Illegal=1 immediately; IllegalSeen=1 after the next clk edge.
  - instruction=0x33 -> Illegal=0, IllegalSeen stays 1.
  - Assert rst with instruction=0x0B on the same edge -> IllegalSeen=0.
- Exhaustive sweep: drive all 128 opcodes -> the safety invariants hold for every value; Illegal=1 exactly for the 118 opcodes not in the decode list.
